id_ex_pipe: RTL and testbench

- Parametrised ID->EX pipeline stage with valid/ready handshake, 2-entry skid buffer, flush, and syscall-halt injection.
- Sits between decode/register-read and execute.
- Lets the hazard unit stall EX (out_ready=0) without a combinational ready path back to ID.
- Lets branch/jump resolution squash the stage (flush).

---
 rtl/id_ex_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_id_ex_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe.sv
// ---------------------------------------------------------------------------
// id_ex_pipe
//
// ID->EX pipeline register with a valid/ready handshake and a one-entry skid
// buffer behind the main register. This gives two entries of storage, so
// in_ready can be a flop instead of a combinational path from out_ready.
// The stage also supports squashing all held entries (flush) and replacing
// the accepted instruction with a halt syscall (halt_ex).
//
// State | Meaning
// ------+------------------------------------------
// EMPTY | nothing held, out_valid=0
// ONE   | main register valid, skid empty
// FULL  | main and skid valid, in_ready=0
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      ID side handshake (in_ready is registered)
//   flush                    squash everything held on the next edge
//   halt_ex                  turn the accepted instruction into a halt syscall
//   pc_in .. rd_in           ID payload
//   out_valid / out_ready    EX side handshake
//   pc_out .. rd_out         registered payload to EX
//
// Optional build macro: ID_EX_PERF_EN adds the saturating 32-bit counters
//   stall_cnt  (cycles with out_valid && !out_ready)
//   bubble_cnt (cycles with !out_valid && !flush)
// ---------------------------------------------------------------------------
module id_ex_pipe #(
    parameter int DATA_W    = 32,
    parameter int CTRL_W    = 16,
    parameter int REG_W     = 5,
    parameter int HALT_CODE = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              halt_ex,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] instr_in,
    input  logic [DATA_W-1:0] rs_data_in,
    input  logic [DATA_W-1:0] rt_data_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              syscall_in,
    input  logic [REG_W-1:0]  rt_in,
    input  logic [REG_W-1:0]  rd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] instr_out,
    output logic [DATA_W-1:0] rs_data_out,
    output logic [DATA_W-1:0] rt_data_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              syscall_out,
    output logic [REG_W-1:0]  rt_out,
    output logic [REG_W-1:0]  rd_out
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [CTRL_W-1:0] ctrl;
        logic              syscall;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
    } payload_t;

    state_t   state_q, state_d;
    payload_t main_q, main_d;
    payload_t skid_q, skid_d;
    logic     in_ready_q, in_ready_d;
    payload_t in_pkt;
    logic     accept, emit;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready_q;
    assign emit      = out_valid && out_ready;

    // Halt injection is applied to the incoming packet, so it only takes
    // effect on an accept.
    always_comb begin
        in_pkt.pc      = pc_in;
        in_pkt.instr   = instr_in;
        in_pkt.rs_data = halt_ex ? DATA_W'(HALT_CODE) : rs_data_in;
        in_pkt.rt_data = rt_data_in;
        in_pkt.imm     = imm_in;
        in_pkt.ctrl    = ctrl_in;
        in_pkt.syscall = halt_ex ? 1'b1 : syscall_in;
        in_pkt.rt      = rt_in;
        in_pkt.rd      = rd_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Flush only clears occupancy; the data registers keep their last value
    // and the bubble gating below hides ctrl/syscall.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_pkt;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && !emit) begin
                        skid_d  = in_pkt;
                        state_d = FULL;
                    end else if (accept && emit) begin
                        main_d  = in_pkt;
                    end else if (emit) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (emit) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != FULL);
    end

    assign pc_out      = main_q.pc;
    assign instr_out   = main_q.instr;
    assign rs_data_out = main_q.rs_data;
    assign rt_data_out = main_q.rt_data;
    assign imm_out     = main_q.imm;
    assign rt_out      = main_q.rt;
    assign rd_out      = main_q.rd;
    // A bubble must never write a register, write memory or trap.
    assign ctrl_out    = out_valid ? main_q.ctrl : '0;
    assign syscall_out = out_valid && main_q.syscall;

`ifdef ID_EX_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (!out_valid && !flush && (bubble_cnt_q != '1))
            bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
module tb_id_ex_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, halt_ex;
    logic [31:0] pc_in, instr_in, rs_data_in, rt_data_in, imm_in;
    logic [15:0] ctrl_in;
    logic        syscall_in;
    logic [4:0]  rt_in, rd_in;
    logic        out_valid, out_ready;
    logic [31:0] pc_out, instr_out, rs_data_out, rt_data_out, imm_out;
    logic [15:0] ctrl_out;
    logic        syscall_out;
    logic [4:0]  rt_out, rd_out;
`ifdef ID_EX_PERF_EN
    logic [31:0] stall_cnt, bubble_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .halt_ex(halt_ex),
        .pc_in(pc_in), .instr_in(instr_in), .rs_data_in(rs_data_in),
        .rt_data_in(rt_data_in), .imm_in(imm_in), .ctrl_in(ctrl_in),
        .syscall_in(syscall_in), .rt_in(rt_in), .rd_in(rd_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .instr_out(instr_out), .rs_data_out(rs_data_out),
        .rt_data_out(rt_data_out), .imm_out(imm_out), .ctrl_out(ctrl_out),
        .syscall_out(syscall_out), .rt_out(rt_out), .rd_out(rd_out)
`ifdef ID_EX_PERF_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    // Secondary payload fields are derived from pc so each packet is unique.
    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction
    function automatic logic [31:0] rtd_of(input logic [31:0] pc);
        return pc + 32'h0000_2000;
    endfunction
    function automatic logic [31:0] imm_of(input logic [31:0] pc);
        return ~pc;
    endfunction
    function automatic logic [15:0] ctrl_of(input logic [31:0] pc);
        return pc[15:0] | 16'h8001;
    endfunction
    function automatic logic [4:0] rt_of(input logic [31:0] pc);
        return pc[6:2];
    endfunction
    function automatic logic [4:0] rd_of(input logic [31:0] pc);
        return pc[6:2] ^ 5'h1F;
    endfunction

    typedef struct {
        logic        iv, ordy, fl, ht, sy;
        logic [31:0] pc, rs;
        logic        e_ov, e_ir;
        logic [31:0] e_pc, e_rs;
        logic        e_sys;
    } vec_t;

    function automatic vec_t mk(input logic iv, ordy, fl, ht, sy,
                                input logic [31:0] pc, rs,
                                input logic e_ov, e_ir,
                                input logic [31:0] e_pc, e_rs,
                                input logic e_sys);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.ht = ht; v.sy = sy;
        v.pc = pc; v.rs = rs; v.e_ov = e_ov; v.e_ir = e_ir;
        v.e_pc = e_pc; v.e_rs = e_rs; v.e_sys = e_sys;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, ordy, fl, ht, sy, input logic [31:0] pc, rs);
        in_valid   = iv;
        out_ready  = ordy;
        flush      = fl;
        halt_ex    = ht;
        syscall_in = sy;
        pc_in      = pc;
        rs_data_in = rs;
        instr_in   = instr_of(pc);
        rt_data_in = rtd_of(pc);
        imm_in     = imm_of(pc);
        ctrl_in    = ctrl_of(pc);
        rt_in      = rt_of(pc);
        rd_in      = rd_of(pc);
    endtask

    task automatic chk_out(input string tag, input logic ov, ir,
                           input logic [31:0] pc, rs, input logic sys);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
        chk({tag, ".in_ready"},  64'(in_ready),  64'(ir));
        chk({tag, ".pc"},        64'(pc_out),    64'(pc));
        chk({tag, ".rs"},        64'(rs_data_out), 64'(rs));
        chk({tag, ".syscall"},   64'(syscall_out), 64'(sys));
        chk({tag, ".ctrl"},      64'(ctrl_out), 64'(ov ? ctrl_of(pc) : 16'h0));
        chk({tag, ".instr"},     64'(instr_out), 64'(instr_of(pc)));
        chk({tag, ".rt_data"},   64'(rt_data_out), 64'(rtd_of(pc)));
        chk({tag, ".imm"},       64'(imm_out),   64'(imm_of(pc)));
        chk({tag, ".rt"},        64'(rt_out),    64'(rt_of(pc)));
        chk({tag, ".rd"},        64'(rd_out),    64'(rd_of(pc)));
    endtask

    vec_t tv[16];

    initial begin
        //           iv ordy fl ht sy  pc         rs_in         ov ir  pc_out     rs_out        sys
        tv[0]  = mk(1, 1, 0, 0, 0, 32'h00,  32'h1000,  1, 1, 32'h00, 32'h1000, 0);
        tv[1]  = mk(1, 1, 0, 0, 0, 32'h04,  32'h1004,  1, 1, 32'h04, 32'h1004, 0);
        tv[2]  = mk(1, 1, 0, 0, 0, 32'h08,  32'h1008,  1, 1, 32'h08, 32'h1008, 0);
        tv[3]  = mk(1, 0, 0, 0, 0, 32'h0C,  32'h100C,  1, 0, 32'h08, 32'h1008, 0);
        tv[4]  = mk(1, 0, 0, 0, 0, 32'h10,  32'h1010,  1, 0, 32'h08, 32'h1008, 0);
        tv[5]  = mk(0, 1, 0, 0, 0, 32'hFF0, 32'hDEAD,  1, 1, 32'h0C, 32'h100C, 0);
        tv[6]  = mk(0, 1, 0, 0, 0, 32'hFF0, 32'hDEAD,  0, 1, 32'h0C, 32'h100C, 0);
        tv[7]  = mk(1, 0, 0, 1, 0, 32'h20,  32'h1234,  1, 1, 32'h20, 32'h000A, 1);
        tv[8]  = mk(1, 0, 0, 0, 1, 32'h24,  32'h1024,  1, 0, 32'h20, 32'h000A, 1);
        tv[9]  = mk(1, 1, 0, 1, 0, 32'h28,  32'h1028,  1, 1, 32'h24, 32'h1024, 1);
        tv[10] = mk(1, 0, 0, 0, 0, 32'h28,  32'h1028,  1, 0, 32'h24, 32'h1024, 1);
        tv[11] = mk(1, 1, 1, 0, 0, 32'h2C,  32'h102C,  0, 1, 32'h24, 32'h1024, 0);
        tv[12] = mk(0, 1, 0, 0, 0, 32'hFF0, 32'hDEAD,  0, 1, 32'h24, 32'h1024, 0);
        tv[13] = mk(1, 1, 0, 0, 0, 32'h30,  32'h1030,  1, 1, 32'h30, 32'h1030, 0);
        tv[14] = mk(1, 0, 1, 0, 0, 32'h34,  32'h1034,  0, 1, 32'h30, 32'h1030, 0);
        tv[15] = mk(0, 1, 0, 0, 0, 32'hFF0, 32'hDEAD,  0, 1, 32'h30, 32'h1030, 0);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.in_ready",  64'(in_ready),  64'd1);
        chk("reset.pc",        64'(pc_out),    64'd0);
        chk("reset.rs",        64'(rs_data_out), 64'd0);
        chk("reset.ctrl",      64'(ctrl_out),  64'd0);
        chk("reset.syscall",   64'(syscall_out), 64'd0);
        chk("reset.rd",        64'(rd_out),    64'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(tv[i].iv, tv[i].ordy, tv[i].fl, tv[i].ht, tv[i].sy, tv[i].pc, tv[i].rs);
            @(posedge clk);
            #1;
            chk_out($sformatf("vec%0d", i), tv[i].e_ov, tv[i].e_ir, tv[i].e_pc,
                    tv[i].e_rs, tv[i].e_sys);
        end

        // Asynchronous reset while FULL, observed before the next clock edge.
        drive(1, 0, 0, 0, 0, 32'h40, 32'h1040);
        @(posedge clk);
        #1;
        drive(1, 0, 0, 0, 0, 32'h44, 32'h1044);
        @(posedge clk);
        #1;
        chk("full.in_ready", 64'(in_ready), 64'd0);
        chk("full.pc",       64'(pc_out),   64'h40);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.out_valid", 64'(out_valid), 64'd0);
        chk("arst.in_ready",  64'(in_ready),  64'd1);
        chk("arst.ctrl",      64'(ctrl_out),  64'd0);
        chk("arst.pc",        64'(pc_out),    64'd0);
        #1;
        rst = 1'b0;
        drive(1, 1, 0, 0, 0, 32'h50, 32'h1050);
        @(posedge clk);
        #1;
        chk_out("post_arst", 1, 1, 32'h50, 32'h1050, 0);
        drive(0, 1, 0, 0, 0, 32'hFF0, 32'hDEAD);
        @(posedge clk);
        #1;
        chk_out("post_arst_drain", 0, 1, 32'h50, 32'h1050, 0);

`ifdef ID_EX_PERF_EN
        begin
            logic [31:0] s0, b0;
            drive(1, 0, 0, 0, 0, 32'h60, 32'h1060);
            @(posedge clk);
            #1;
            s0 = stall_cnt;
            b0 = bubble_cnt;
            drive(0, 0, 0, 0, 0, 32'hFF0, 32'hDEAD);
            repeat (3) @(posedge clk);
            #1;
            chk("perf.stall", 64'(stall_cnt - s0), 64'd3);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            repeat (2) @(posedge clk);
            #1;
            chk("perf.bubble", 64'(bubble_cnt - b0), 64'd2);
            chk("perf.stall_hold", 64'(stall_cnt - s0), 64'd3);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
